// File: rtl/gpio_config_shadow_if.sv
// rtl/gpio_config_shadow_if.sv - Interface bundling the shift/commit controls and pad configuration outputs
//
// Purpose : groups the serial shift chain, the load/restore strobes and the
//           active configuration / decoded pad controls of one GPIO pad.
// Signals :
//   gpio_defaults [CFG_BITS] static default word (controller -> pad)
//   shift_en, shift_din      serial load strobe and data, MSB first
//   shift_dout               MSB of the shift register, to the next pad
//   load, restore            one-cycle commit / restore-defaults strobes
//   cfg [CFG_BITS]           active configuration word
//   cfg_update               one-cycle pulse after cfg changes
//   load_err                 sticky bad-bit-count flag
//   busy                     commit sequence in progress
//   mgmt_en..drive           decoded pad control fields
// Modports: master = configuration controller, slave = gpio_config_shadow.
interface gpio_config_shadow_if #(
    parameter int CFG_BITS = 10
);
    logic [CFG_BITS-1:0] gpio_defaults;
    logic                shift_en;
    logic                shift_din;
    logic                shift_dout;
    logic                load;
    logic                restore;
    logic [CFG_BITS-1:0] cfg;
    logic                cfg_update;
    logic                load_err;
    logic                busy;
    logic                mgmt_en;
    logic                oe_ovr;
    logic                ie;
    logic                pu;
    logic                pd;
    logic                slew;
    logic [1:0]          drive;

    modport master (
        output gpio_defaults, shift_en, shift_din, load, restore,
        input  shift_dout, cfg, cfg_update, load_err, busy,
        input  mgmt_en, oe_ovr, ie, pu, pd, slew, drive
    );

    modport slave (
        input  gpio_defaults, shift_en, shift_din, load, restore,
        output shift_dout, cfg, cfg_update, load_err, busy,
        output mgmt_en, oe_ovr, ie, pu, pd, slew, drive
    );
endinterface

// File: rtl/gpio_config_shadow.sv
// rtl/gpio_config_shadow.sv - Per-pad configuration shadow with serial load and checked two-cycle commit
//
// Purpose : holds the active configuration of one user GPIO pad. The word is
//           taken from gpio_defaults at reset or on restore, or replaced by a
//           word shifted in serially and committed through CHECK -> COMMIT.
// Ports   :
//   wb_clk_i   single clock, rising edge
//   wb_rst_i   synchronous active-high reset
//   bus        gpio_config_shadow_if.slave (shift chain, strobes, cfg and
//              decoded pad controls)
module gpio_config_shadow #(
    parameter int CFG_BITS = 10,
    parameter int CNT_W    = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    gpio_config_shadow_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};

    state_t              r_state;
    logic [CFG_BITS-1:0] r_cfg;
    logic [CFG_BITS-1:0] r_shift;
    logic [CNT_W-1:0]    r_count;
    logic                r_load_err;
    logic                r_cfg_update;

    state_t              w_state_nxt;
    logic [CFG_BITS-1:0] w_cfg_nxt;
    logic [CFG_BITS-1:0] w_shift_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_load_err_nxt;
    logic                w_cfg_update_nxt;

    // State and datapath registers. Reset aborts any sequence in flight, so a
    // pending COMMIT can never partially land.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_cfg        <= bus.gpio_defaults;
            r_shift      <= '0;
            r_count      <= '0;
            r_load_err   <= 1'b0;
            r_cfg_update <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cfg        <= w_cfg_nxt;
            r_shift      <= w_shift_nxt;
            r_count      <= w_count_nxt;
            r_load_err   <= w_load_err_nxt;
            r_cfg_update <= w_cfg_update_nxt;
        end
    end

    // Next-state and datapath logic. Strobes are only honoured in IDLE;
    // anything arriving during CHECK/COMMIT is dropped, not queued.
    always_comb begin
        w_state_nxt      = r_state;
        w_cfg_nxt        = r_cfg;
        w_shift_nxt      = r_shift;
        w_count_nxt      = r_count;
        w_load_err_nxt   = r_load_err;
        w_cfg_update_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.restore) begin
                    // restore wins and swallows any same-cycle load/shift
                    w_cfg_nxt        = bus.gpio_defaults;
                    w_shift_nxt      = '0;
                    w_count_nxt      = '0;
                    w_load_err_nxt   = 1'b0;
                    w_cfg_update_nxt = 1'b1;
                end else begin
                    // a shift coincident with load lands first, so CHECK
                    // sees the updated count
                    if (bus.shift_en) begin
                        w_shift_nxt = {r_shift[CFG_BITS-2:0], bus.shift_din};
                        if (r_count != LP_CNT_MAX) begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                    if (bus.load) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (r_count == LP_CNT_FULL) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_load_err_nxt = 1'b1;
                    w_count_nxt    = '0;
                    w_state_nxt    = ST_IDLE;
                end
            end

            ST_COMMIT: begin
                // shift register is kept so shift_dout still shows its MSB
                w_cfg_nxt        = r_shift;
                w_load_err_nxt   = 1'b0;
                w_count_nxt      = '0;
                w_cfg_update_nxt = 1'b1;
                w_state_nxt      = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.cfg        = r_cfg;
    assign bus.cfg_update = r_cfg_update;
    assign bus.load_err   = r_load_err;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.shift_dout = r_shift[CFG_BITS-1];

    // Decoded pad controls; cfg[9:8] are reserved and only carried in cfg.
    assign bus.mgmt_en = r_cfg[0];
    assign bus.oe_ovr  = r_cfg[1];
    assign bus.ie      = r_cfg[2];
    assign bus.pu      = r_cfg[3];
    assign bus.pd      = r_cfg[4];
    assign bus.slew    = r_cfg[5];
    assign bus.drive   = r_cfg[7:6];

endmodule

// File: tb/tb_gpio_config_shadow.sv
// tb/tb_gpio_config_shadow.sv - Directed self-checking bench for gpio_config_shadow
module tb_gpio_config_shadow;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    gpio_config_shadow_if #(.CFG_BITS(10)) bus ();

    gpio_config_shadow #(.CFG_BITS(10), .CNT_W(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // inputs are changed and outputs sampled at the falling edge
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic [9:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.shift_en  = 1'b1;
            bus.shift_din = val[i];
            cyc();
        end
        bus.shift_en  = 1'b0;
        bus.shift_din = 1'b0;
    endtask

    task automatic pulse_load();
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    // load already sampled; walk N+1..N+3 for a load that must succeed
    task automatic expect_commit(input string tag, input logic [9:0] old_cfg, input logic [9:0] new_cfg);
        check({tag, "_n1_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_n1_upd"}, 32'(bus.cfg_update), 32'd0);
        cyc();
        check({tag, "_n2_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_n2_cfg"}, 32'(bus.cfg), 32'(old_cfg));
        cyc();
        check({tag, "_n3_cfg"}, 32'(bus.cfg), 32'(new_cfg));
        check({tag, "_n3_upd"}, 32'(bus.cfg_update), 32'd1);
        check({tag, "_n3_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_n3_err"}, 32'(bus.load_err), 32'd0);
        cyc();
        check({tag, "_n4_upd"}, 32'(bus.cfg_update), 32'd0);
    endtask

    task automatic expect_fail(input string tag, input logic [9:0] keep_cfg);
        check({tag, "_n1_busy"}, 32'(bus.busy), 32'd1);
        cyc();
        check({tag, "_n2_err"}, 32'(bus.load_err), 32'd1);
        check({tag, "_n2_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_n2_upd"}, 32'(bus.cfg_update), 32'd0);
        cyc();
        check({tag, "_n3_cfg"}, 32'(bus.cfg), 32'(keep_cfg));
        check({tag, "_n3_upd"}, 32'(bus.cfg_update), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.gpio_defaults = 10'h007;
        bus.shift_en  = 1'b0;
        bus.shift_din = 1'b0;
        bus.load      = 1'b0;
        bus.restore   = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // reset state
        check("rst_cfg", 32'(bus.cfg), 32'h007);
        check("rst_mgmt_en", 32'(bus.mgmt_en), 32'd1);
        check("rst_oe_ovr", 32'(bus.oe_ovr), 32'd1);
        check("rst_ie", 32'(bus.ie), 32'd1);
        check("rst_pu", 32'(bus.pu), 32'd0);
        check("rst_pd", 32'(bus.pd), 32'd0);
        check("rst_upd", 32'(bus.cfg_update), 32'd0);
        check("rst_err", 32'(bus.load_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // full 10-bit load of 0x2A5 and field decode
        shift_bits(10'h2A5, 10);
        check("sh_dout", 32'(bus.shift_dout), 32'd1);
        pulse_load();
        expect_commit("ld2a5", 10'h007, 10'h2A5);
        check("dec_drive", 32'(bus.drive), 32'd2);
        check("dec_slew", 32'(bus.slew), 32'd1);
        check("dec_pd", 32'(bus.pd), 32'd0);
        check("dec_pu", 32'(bus.pu), 32'd0);
        check("dec_ie", 32'(bus.ie), 32'd1);
        check("dec_oe_ovr", 32'(bus.oe_ovr), 32'd0);
        check("dec_mgmt_en", 32'(bus.mgmt_en), 32'd1);

        // restore back to defaults
        bus.restore = 1'b1;
        cyc();
        bus.restore = 1'b0;
        check("rs_cfg", 32'(bus.cfg), 32'h007);
        check("rs_upd", 32'(bus.cfg_update), 32'd1);
        check("rs_dout", 32'(bus.shift_dout), 32'd0);
        cyc();
        check("rs_upd_off", 32'(bus.cfg_update), 32'd0);

        // 9 bits -> load error, then a good 10-bit load clears it
        shift_bits(10'h155, 9);
        pulse_load();
        expect_fail("short", 10'h007);
        shift_bits(10'h155, 10);
        pulse_load();
        expect_commit("ld155", 10'h007, 10'h155);

        // 12 bits -> count exceeds the word width, load rejected
        shift_bits(10'h3C3, 10);
        shift_bits(10'h003, 2);
        pulse_load();
        expect_fail("long", 10'h155);

        // 10th shift coincident with load; shift/restore during CHECK/COMMIT ignored
        shift_bits(10'h1B3 >> 1, 9);
        bus.shift_en  = 1'b1;
        bus.shift_din = 1'b1;
        bus.load      = 1'b1;
        cyc();
        bus.load      = 1'b0;
        bus.restore   = 1'b1;
        check("co_n1_busy", 32'(bus.busy), 32'd1);
        cyc();
        check("co_n2_busy", 32'(bus.busy), 32'd1);
        check("co_n2_dout", 32'(bus.shift_dout), 32'd0);
        cyc();
        bus.shift_en  = 1'b0;
        bus.shift_din = 1'b0;
        bus.restore   = 1'b0;
        check("co_cfg", 32'(bus.cfg), 32'h1B3);
        check("co_upd", 32'(bus.cfg_update), 32'd1);
        check("co_dout", 32'(bus.shift_dout), 32'd0);
        check("co_err", 32'(bus.load_err), 32'd0);
        cyc();
        check("co_upd_off", 32'(bus.cfg_update), 32'd0);
        check("co_dout_hold", 32'(bus.shift_dout), 32'd0);

        // restore together with load: restore wins, FSM stays IDLE
        shift_bits(10'h2A5, 10);
        pulse_load();
        expect_commit("ld2a5b", 10'h1B3, 10'h2A5);
        bus.restore = 1'b1;
        bus.load    = 1'b1;
        cyc();
        bus.restore = 1'b0;
        bus.load    = 1'b0;
        check("rl_cfg", 32'(bus.cfg), 32'h007);
        check("rl_upd", 32'(bus.cfg_update), 32'd1);
        check("rl_busy", 32'(bus.busy), 32'd0);
        cyc();
        check("rl_upd_off", 32'(bus.cfg_update), 32'd0);
        check("rl_busy2", 32'(bus.busy), 32'd0);
        check("rl_cfg2", 32'(bus.cfg), 32'h007);

        // reset during CHECK aborts the commit
        shift_bits(10'h3FF, 10);
        check("ab_dout_pre", 32'(bus.shift_dout), 32'd1);
        pulse_load();
        check("ab_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("ab_cfg", 32'(bus.cfg), 32'h007);
        check("ab_upd", 32'(bus.cfg_update), 32'd0);
        check("ab_dout", 32'(bus.shift_dout), 32'd0);
        check("ab_busy", 32'(bus.busy), 32'd0);
        cyc();
        check("ab_cfg2", 32'(bus.cfg), 32'h007);
        check("ab_upd2", 32'(bus.cfg_update), 32'd0);

        // defaults changing outside reset/restore leave cfg alone
        bus.gpio_defaults = 10'h0AA;
        cyc();
        cyc();
        check("dflt_static", 32'(bus.cfg), 32'h007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
